// File: rtl/uart_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_decoder_pkg
//  Brief    : Shared types and default parameters for the UART frame decoder.
//  Revision : 1.0
// ============================================================================
package uart_frame_decoder_pkg;

    localparam logic [7:0] c_sync_byte      = 8'hA5;
    localparam int         c_max_len        = 16;
    localparam int         c_timeout_cycles = 20000;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        HOLD    = 3'd4
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_decoder_if
//  Brief    : RX FIFO pop side plus frame-consumer side of the frame decoder.
//  Revision : 1.0
// ============================================================================
interface uart_frame_decoder_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          rx_empty;
    logic [7:0]    rx_data;
    logic          rd_uart;
    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          frame_ack;
    logic          chk_err;
    logic          len_err;
    logic          timeout_err;
    logic [7:0]    err_cnt;

    modport slave (
        input  rx_empty, rx_data, buf_addr, frame_ack,
        output rd_uart, frame_valid, frame_len, buf_data,
               chk_err, len_err, timeout_err, err_cnt
    );

    modport master (
        output rx_empty, rx_data, buf_addr, frame_ack,
        input  rd_uart, frame_valid, frame_len, buf_data,
               chk_err, len_err, timeout_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_decoder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_buffer
//  Brief    : MAX_LEN x 8 payload RAM, one write port, one registered read port.
//  Revision : 1.0
// ============================================================================
module uart_frame_buffer #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    // Addresses beyond the RAM depth read back as zero rather than X.
    always_comb begin
        rd_data_d = (32'(rd_addr) < MAX_LEN) ? mem_q[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_decoder
//  Brief    : Hunts [SYNC][LEN][payload][CHK] frames from the RX FIFO and holds
//             each good frame until acknowledged.
//  Revision : 1.0
// ============================================================================
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = c_sync_byte,
    parameter int         MAX_LEN        = c_max_len,
    parameter int         TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_decoder_if.slave bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    frame_state_t  state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_valid_q, frame_valid_d;
    logic [LW-1:0] frame_len_q, frame_len_d;
    logic          chk_err_q, chk_err_d;
    logic          len_err_q, len_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          w_pop;
    logic          w_wr_en;
    logic [7:0]    w_buf_data;

    assign w_pop = !bus.rx_empty && (state_q != HOLD);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        timer_d       = '0;
        frame_valid_d = frame_valid_q;
        frame_len_d   = frame_len_q;
        chk_err_d     = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        err_cnt_d     = err_cnt_q;
        w_wr_en       = 1'b0;

        case (state_q)
            HUNT: begin
                if (w_pop && bus.rx_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (w_pop) begin
                    if (bus.rx_data == 8'h00 || bus.rx_data > 8'(MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = HUNT;
                    end else begin
                        len_d   = bus.rx_data[LW-1:0];
                        chk_d   = bus.rx_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_pop) begin
                    w_wr_en = 1'b1;
                    chk_d   = chk_q ^ bus.rx_data;
                    idx_d   = idx_q + 1'b1;
                    if (LW'(idx_q) == len_q - LW'(1)) state_d = CHK;
                end
            end
            CHK: begin
                if (w_pop) begin
                    if (bus.rx_data == chk_q) begin
                        frame_valid_d = 1'b1;
                        frame_len_d   = len_q;
                        state_d       = HOLD;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            HOLD: begin
                if (bus.frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        // Idle cycles inside a frame; a pop on the final cycle still wins.
        if ((state_q inside {LEN, PAYLOAD, CHK}) && !w_pop) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_err_d = 1'b1;
                state_d       = HUNT;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if ((chk_err_d || len_err_d || timeout_err_d) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            timer_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            chk_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            timer_q       <= timer_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            chk_err_q     <= chk_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    uart_frame_buffer #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (idx_q),
        .wr_data (bus.rx_data),
        .rd_addr (bus.buf_addr),
        .rd_data (w_buf_data)
    );

    assign bus.rd_uart     = w_pop;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.buf_data    = w_buf_data;
    assign bus.chk_err     = chk_err_q;
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_frame_decoder
//  Brief    : Frame-level reference model plus randomized and directed stimulus.
//  Revision : 1.0
// ============================================================================
module tb_uart_frame_decoder;
    localparam int T_CYC = 200;
    localparam int ML    = 16;

    logic clk;
    logic reset;

    uart_frame_decoder_if #(.MAX_LEN(ML)) bus ();

    uart_frame_decoder #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (ML),
        .TIMEOUT_CYCLES (T_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit rnd_mode = 0;

    logic [7:0] fifo [$];
    bit         drv_reset, drv_ack;
    logic [3:0] drv_addr;
    bit         a_reset, a_empty, a_ack;
    logic [7:0] a_data;
    logic [3:0] a_addr;

    // Reference model: frame-level view of the consumed byte stream.
    bit         m_in = 0, m_hold = 0;
    logic [7:0] m_cur [$];
    int         m_idle = 0, m_len = 0;
    logic [7:0] m_buf [ML];

    logic       e_rd = 0, e_fv = 0, e_chk = 0, e_lenerr = 0, e_to = 0, e_bd_valid = 0;
    logic [4:0] e_len = 0;
    logic [7:0] e_cnt = 0, e_bd = 0;
    int n_chk = 0, n_len = 0, n_to = 0, n_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        logic [7:0] x;
        pop = !a_empty && !m_hold;
        if (pop) void'(fifo.pop_front());
        e_bd_valid = !a_reset && m_hold && (int'(a_addr) < m_len);
        e_bd = m_buf[a_addr];
        e_chk = 0; e_lenerr = 0; e_to = 0;
        if (a_reset) begin
            m_in = 0; m_hold = 0; m_cur.delete(); m_idle = 0; m_len = 0;
            e_fv = 0; e_len = 0; e_cnt = 0;
            return;
        end
        if (m_hold) begin
            if (a_ack) begin m_hold = 0; e_fv = 0; end
        end else if (pop) begin
            m_idle = 0;
            if (!m_in) begin
                if (a_data == 8'hA5) begin m_in = 1; m_cur.delete(); end
            end else begin
                m_cur.push_back(a_data);
                if (m_cur.size() == 1) begin
                    if (a_data == 0 || a_data > ML) begin e_lenerr = 1; m_in = 0; end
                end else if (m_cur.size() == int'(m_cur[0]) + 2) begin
                    x = 0;
                    for (int i = 0; i < m_cur.size() - 1; i++) x ^= m_cur[i];
                    m_in = 0;
                    if (x == a_data) begin
                        m_hold = 1; e_fv = 1; m_len = int'(m_cur[0]); e_len = 5'(m_cur[0]);
                        for (int i = 0; i < m_len; i++) m_buf[i] = m_cur[i+1];
                    end else e_chk = 1;
                end
            end
        end else if (m_in) begin
            m_idle++;
            if (m_idle == T_CYC) begin e_to = 1; m_in = 0; m_idle = 0; end
        end
        if ((e_chk || e_lenerr || e_to) && e_cnt != 8'hFF) e_cnt++;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        if (rnd_mode) begin
            drv_addr  = 4'($urandom);
            drv_ack   = ($urandom % 8) == 0;
            drv_reset = ($urandom % 3000) == 0;
        end
        a_reset = drv_reset; a_empty = (fifo.size() == 0);
        a_data  = a_empty ? 8'($urandom) : fifo[0];
        a_ack   = drv_ack; a_addr = drv_addr;
        reset = a_reset; bus.rx_empty = a_empty; bus.rx_data = a_data;
        bus.frame_ack = a_ack; bus.buf_addr = a_addr;
        e_rd = !a_empty && !m_hold;
        @(negedge clk); #1;
        model_step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_uart", bus.rd_uart, e_rd);
            check("frame_valid", bus.frame_valid, e_fv);
            if (e_fv) check("frame_len", bus.frame_len, e_len);
            check("chk_err", bus.chk_err, e_chk);
            check("len_err", bus.len_err, e_lenerr);
            check("timeout_err", bus.timeout_err, e_to);
            check("err_cnt", bus.err_cnt, e_cnt);
            if (e_bd_valid) check("buf_data", bus.buf_data, e_bd);
            n_chk += int'(bus.chk_err); n_len += int'(bus.len_err);
            n_to  += int'(bus.timeout_err); n_rd += int'(bus.rd_uart);
        end
    end

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic sendn(input int n, input logic [63:0] b);
        for (int i = n - 1; i >= 0; i--) fifo.push_back(b[i*8 +: 8]);
    endtask

    task automatic read_buf(input logic [3:0] addr, output logic [7:0] d);
        drv_addr = addr; cycle(); cycle();
        d = bus.buf_data;
    endtask

    task automatic ack();
        drv_ack = 1; cycle(); drv_ack = 0; cycle();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (fifo.size() != 0 && n < budget) begin cycle(); n++; end
        check("drain_budget", n < budget, 1);
        run(3);
    endtask

    task automatic feed(input logic [7:0] b);
        int g;
        fifo.push_back(b);
        if ($urandom % 30 == 0) g = T_CYC - 3 + int'($urandom % 6);
        else g = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
        repeat (g) cycle();
    endtask

    task automatic gen_frame(input int kind);
        int len; logic [7:0] b, x;
        case (kind)
            0, 1, 2: begin
                len = 1 + int'($urandom % ML);
                feed(8'hA5); feed(8'(len)); x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    b = ($urandom % 6 == 0) ? 8'hA5 : 8'($urandom);
                    x ^= b; feed(b);
                end
                feed(kind == 2 ? (x ^ 8'(1 + $urandom % 255)) : x);
            end
            3: begin
                feed(8'hA5);
                feed(($urandom % 2 == 0) ? 8'h00 : 8'(17 + $urandom % 239));
            end
            4: begin
                repeat (1 + $urandom % 4) feed(8'($urandom % 8'hA5));
            end
            default: begin
                feed(8'hA5); feed(8'h08);
                repeat ($urandom % 6) feed(8'($urandom));
                run(T_CYC + 5);
            end
        endcase
    endtask

    logic [7:0] d;
    int base;

    initial begin
        reset = 1; drv_reset = 1; drv_ack = 0; drv_addr = 0;
        bus.rx_empty = 1; bus.rx_data = 0; bus.frame_ack = 0; bus.buf_addr = 0;
        cycle(); chk_en = 1; cycle(); drv_reset = 0; cycle();
        check("reset_fv", bus.frame_valid, 0);
        check("reset_err_cnt", bus.err_cnt, 0);
        check("reset_frame_len", bus.frame_len, 0);

        // Good frame
        sendn(6, 64'hA5_03_12_34_56_73); run(10);
        check("good_fv", bus.frame_valid, 1);
        check("good_len", bus.frame_len, 3);
        read_buf(0, d); check("good_buf0", d, 8'h12);
        read_buf(1, d); check("good_buf1", d, 8'h34);
        read_buf(2, d); check("good_buf2", d, 8'h56);
        ack(); check("good_ack_fv", bus.frame_valid, 0);

        // Leading junk, sync byte as payload (checksum 01^A5 = A4)
        sendn(7, 64'hFF_00_5A_A5_01_A5_A4); run(12);
        check("junk_len", bus.frame_len, 1);
        read_buf(0, d); check("junk_buf0", d, 8'hA5);
        check("junk_err_cnt", bus.err_cnt, 0);
        ack();

        // Bad checksum then good frame
        base = n_chk;
        sendn(5, 64'hA5_02_10_20_31); run(10);
        check("badchk_pulse", n_chk - base, 1);
        check("badchk_err_cnt", bus.err_cnt, 1);
        check("badchk_fv", bus.frame_valid, 0);
        sendn(4, 64'hA5_01_77_76); run(8);
        check("after_badchk_fv", bus.frame_valid, 1);
        ack();

        // Length errors
        base = n_len;
        sendn(4, 64'hA5_00_A5_11); run(8);
        check("len_pulses", n_len - base, 2);
        check("len_err_cnt", bus.err_cnt, 3);

        // Timeout
        base = n_to;
        sendn(3, 64'hA5_02_12); run(T_CYC + 10);
        check("timeout_once", n_to - base, 1);
        check("timeout_err_cnt", bus.err_cnt, 4);
        sendn(4, 64'hA5_01_77_76); run(8);
        check("after_to_fv", bus.frame_valid, 1);
        read_buf(0, d); check("after_to_buf0", d, 8'h77);
        ack();

        // Backpressure: second frame waits in the FIFO during HOLD
        sendn(6, 64'hA5_03_12_34_56_73); sendn(5, 64'hA5_02_AB_CD_64); run(10);
        base = n_rd; run(100);
        check("hold_no_pop", n_rd - base, 0);
        ack(); run(8);
        check("bp_fv", bus.frame_valid, 1);
        check("bp_len", bus.frame_len, 2);
        read_buf(0, d); check("bp_buf0", d, 8'hAB);
        read_buf(1, d); check("bp_buf1", d, 8'hCD);
        ack();

        // Reset in PAYLOAD
        sendn(5, 64'hA5_04_01_02_03); run(3);
        drv_reset = 1; cycle(); drv_reset = 0; cycle();
        check("rst_fv", bus.frame_valid, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        wait_drain(50);
        sendn(4, 64'hA5_01_77_76); run(8);
        check("rst_next_fv", bus.frame_valid, 1);
        ack();

        // Randomized traffic
        rnd_mode = 1;
        for (int f = 0; f < 250; f++) gen_frame(int'($urandom % 6));
        rnd_mode = 0; drv_reset = 0;
        drv_ack = 1; wait_drain(5000); run(T_CYC + 5); drv_ack = 0;

        // err_cnt saturation
        drv_reset = 1; cycle(); drv_reset = 0; cycle();
        check("sat_start", bus.err_cnt, 0);
        repeat (254) sendn(2, 64'hA5_00);
        wait_drain(2000);
        check("sat_fe", bus.err_cnt, 8'hFE);
        repeat (3) sendn(2, 64'hA5_00);
        wait_drain(100);
        check("sat_ff", bus.err_cnt, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
